// File: rtl/data_memory_param_pkg.sv
// Shared types and sizing helpers for the parametrised CPU data memory.
// The clear-sweep FSM state type is visible to the bench through the debug port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } dmem_state_t;

  localparam int DEFAULT_DEPTH = 16384;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

  // Pointer width for an arbitrary depth; a single-word memory still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// CPU-side bus of the data memory: write/read port, clear-sweep control and status flags.
// Handshake: load is accepted only on an edge where busy=0 and done=0; loads seen while the
// sweep runs are dropped, so the CPU polls busy before writing. done/addr_err are 1-cycle pulses.
interface data_memory_param_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);

  logic              initialize;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              busy;
  logic              done;
  logic              addr_err;
  dmem_state_t       dbg_state;

  modport master (
    output initialize,
    output load,
    output address,
    output in,
    input  out,
    input  busy,
    input  done,
    input  addr_err,
    input  dbg_state
  );

  modport slave (
    input  initialize,
    input  load,
    input  address,
    input  in,
    output out,
    output busy,
    output done,
    output addr_err,
    output dbg_state
  );

endinterface

// File: rtl/data_memory_param_array.sv
// Single-port storage for the data memory: sweep/CPU write mux, one read port,
// and a choice of combinational or registered (read-first) read data.
module dmem_array #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16384,
  parameter int PW      = 14,
  parameter int REG_OUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sweep_we,
  input  logic [PW-1:0]     sweep_addr,
  input  logic [DATA_W-1:0] fill,
  input  logic              cpu_we,
  input  logic [PW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              rd_en,
  input  logic [PW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [PW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;

  // The sweep owns the port while it runs; a reset cycle never writes,
  // so an aborted sweep stops cleanly at the word it had reached.
  always_comb begin
    we    = (sweep_we | cpu_we) & ~rst;
    waddr = cpu_addr;
    wdata = cpu_wdata;
    if (sweep_we) begin
      waddr = sweep_addr;
      wdata = fill;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_read
      logic [DATA_W-1:0] rdata_q;

      // Read-first: the old word is captured on the same edge a write lands.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rd_en ? mem[rd_addr] : '0;
        end
      end

      assign rdata = rdata_q;
    end else begin : g_comb_read
      assign rdata = rd_en ? mem[rd_addr] : '0;
    end
  endgenerate

endmodule

// File: rtl/data_memory_param.sv
// Parametrised CPU data memory with a hardware clear sweep, busy/done status,
// selectable registered read port and out-of-range address detection.
module data_memory_param
  import dmem_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 15,
  parameter int                DEPTH   = 16384,
  parameter int                REG_OUT = 0,
  parameter logic [DATA_W-1:0] FILL    = '0
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_param_if.slave bus
);

  localparam int              PW      = ptr_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);

  dmem_state_t   state;
  logic [PW-1:0] ptr;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          idle;
  logic          in_range;
  logic [PW-1:0] cpu_idx;

  // Full-width compare: addresses past DEPTH never alias onto low words.
  assign idle     = (state == IDLE);
  assign in_range = ({1'b0, bus.address} < DEPTH_L);
  assign cpu_idx  = in_range ? bus.address[PW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= idle && !in_range;
      case (state)
        IDLE: begin
          if (bus.initialize) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST) begin
            state  <= DONE;
            ptr    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            ptr <= ptr + PW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .PW      (PW),
    .REG_OUT (REG_OUT)
  ) u_array (
    .clk        (clk),
    .rst        (reset),
    .sweep_we   (state == CLEAR),
    .sweep_addr (ptr),
    .fill       (FILL),
    .cpu_we     (bus.load && idle && in_range),
    .cpu_addr   (cpu_idx),
    .cpu_wdata  (bus.in),
    .rd_en      (idle && in_range),
    .rd_addr    (cpu_idx),
    .rdata      (bus.out)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.addr_err  = err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: one combinational-read and one registered-read
// instance (DEPTH=16, FILL=0xA5A5) checked against an expected-value queue.
module tb_data_memory_param;
  import dmem_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 16;
  localparam logic [DATA_W-1:0] FILL = 16'hA5A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b0 ();
  data_memory_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();

  data_memory_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .REG_OUT(0), .FILL(FILL)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  data_memory_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .REG_OUT(1), .FILL(FILL)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  logic [DATA_W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [DATA_W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs);
    logic [DATA_W-1:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic wr0(input int a, input logic [DATA_W-1:0] d);
    b0.load    = 1'b1;
    b0.address = ADDR_W'(a);
    b0.in      = d;
    tick();
    b0.load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen_done;
    logic [1:0] flags;

    reset         = 1'b1;
    b0.initialize = 1'b0; b0.load = 1'b0; b0.address = '0; b0.in = '0;
    b1.initialize = 1'b0; b1.load = 1'b0; b1.address = '0; b1.in = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    expect_val(16'd0); check("rst_busy", 16'(b0.busy));
    expect_val(16'd0); check("rst_done", 16'(b0.done));
    expect_val(16'd0); check("rst_addr_err", 16'(b0.addr_err));
    expect_val(16'(IDLE)); check("rst_state", 16'(b0.dbg_state));
    expect_val(16'd0); check("rst_regout", b1.out);

    // 1: combinational read, no latency
    tick();
    wr0(0, 16'd3);
    wr0(1, 16'd4);
    b0.address = '0;
    expect_val(16'd3);
    @(negedge clk); check("t1_rd0", b0.out);
    b0.address = ADDR_W'(1);
    expect_val(16'd4);
    #1 check("t1_rd1", b0.out);

    // 2: registered read-during-write returns old word first
    tick();
    b1.load = 1'b1; b1.address = ADDR_W'(5); b1.in = 16'h1111;
    tick();
    b1.in = 16'hBEEF;
    tick();
    b1.load = 1'b0;
    expect_val(16'h1111);
    @(negedge clk); check("t2_old_word", b1.out);
    tick();
    expect_val(16'hBEEF);
    @(negedge clk); check("t2_new_word", b1.out);

    // 3: clear sweep, timing, forced-zero output, dropped mid-sweep load
    tick();
    b0.address    = '0;
    b0.initialize = 1'b1;
    tick();
    b0.initialize = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!b0.busy) break;
      n++;
      if (n == 5) begin
        b0.load = 1'b1; b0.address = ADDR_W'(3); b0.in = 16'hFFFF;
      end else begin
        b0.load = 1'b0; b0.address = '0;
      end
      if (n == 8) begin
        expect_val(16'd0); #1 check("t3_out_forced", b0.out);
      end
    end
    b0.load = 1'b0;
    expect_val(16'd16); check("t3_busy_cycles", 16'(n));
    expect_val(16'd1);  check("t3_done_pulse", 16'(b0.done));
    @(negedge clk);
    expect_val(16'd0);  check("t3_done_low", 16'(b0.done));
    for (int a = 0; a < DEPTH; a++) begin
      b0.address = ADDR_W'(a);
      expect_val(FILL);
      #1 check($sformatf("t3_fill_%0d", a), b0.out);
    end

    // 4: reset mid-sweep at ptr=7
    tick();
    for (int a = 0; a < DEPTH; a++) wr0(a, 16'(16'h1000 + a));
    b0.initialize = 1'b1;
    tick();
    b0.initialize = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    @(negedge clk);
    expect_val(16'd1); check("t4_busy_before", 16'(b0.busy));
    tick();
    reset = 1'b0;
    @(negedge clk);
    expect_val(16'd0); check("t4_busy_dropped", 16'(b0.busy));
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b0.done) seen_done++;
    end
    expect_val(16'd0); check("t4_no_done", 16'(seen_done));
    for (int a = 0; a < 7; a++) begin
      b0.address = ADDR_W'(a);
      expect_val(FILL);
      #1 check($sformatf("t4_swept_%0d", a), b0.out);
    end
    b0.address = ADDR_W'(8);
    expect_val(16'h1008);
    #1 check("t4_kept_8", b0.out);
    b0.address = ADDR_W'(15);
    expect_val(16'h100F);
    #1 check("t4_kept_15", b0.out);

    // 5: out-of-range write/read
    tick();
    b0.load = 1'b1; b0.address = ADDR_W'(16); b0.in = 16'h1234;
    expect_val(16'd0);
    #1 check("t5_rd16_zero", b0.out);
    tick();
    b0.load = 1'b0; b0.address = '0;
    @(negedge clk);
    expect_val(16'd1);  check("t5_err_pulse", 16'(b0.addr_err));
    expect_val(FILL);   check("t5_word0_kept", b0.out);
    tick();
    @(negedge clk);
    expect_val(16'd0);  check("t5_err_cleared", 16'(b0.addr_err));
    b1.address = ADDR_W'(16);
    tick();
    expect_val(16'd0);
    @(negedge clk); check("t5_reg_rd16_zero", b1.out);
    b1.address = '0;

    // 6: initialize held high -> back-to-back sweeps
    tick();
    b0.initialize = 1'b1;
    tick();
    for (int i = 0; i < 34; i++) begin
      if (i < 16 || i >= 18) expect_val(16'b10);
      else if (i == 16)      expect_val(16'b01);
      else                   expect_val(16'b00);
    end
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      flags = {b0.busy, b0.done};
      check($sformatf("t6_cycle_%0d", i), 16'(flags));
    end
    b0.initialize = 1'b0;
    n = 0;
    while (b0.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    expect_val(16'd0); check("t6_sweep_ends", 16'(b0.busy));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
